// File: rtl/oppm_pkg.sv
// oppm_pkg: shared OPPM types and sizing helpers for encoder and decoder.
package oppm_pkg;
  typedef enum logic [1:0] {HUNT, PREAM, GAP, DATA} state_t;
  function automatic int frame_len(input int n_mod, input int l);
    return (1 << n_mod) * l;
  endfunction
  function automatic int sym_ct(input int n_pkt, input int n_mod);
    return n_pkt / n_mod;
  endfunction
  function automatic int cnt_w(input int x);
    return $clog2(x + 1);
  endfunction
endpackage

// File: rtl/oppm_window_timer.sv
// oppm_window_timer: slot/symbol position within the current frame window.
module oppm_window_timer import oppm_pkg::*; #(
  parameter int N_MOD = 2,
  parameter int L     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  output logic [N_MOD-1:0] sym,
  output logic             win_end
);
  localparam int SW = cnt_w(L - 1);
  logic [SW-1:0] slot_q, slot_d, slot_c;
  logic [N_MOD-1:0] sym_q, sym_d, sym_c;
  logic wrap;
  // a load makes the current cycle count as q = L/2, so the next cycle is one past it
  always_comb begin
    slot_c = load ? SW'(L / 2) : slot_q;
    sym_c = load ? '0 : sym_q;
    wrap = slot_c == SW'(L - 1);
    slot_d = !(run || load) ? '0 : wrap ? '0 : slot_c + SW'(1);
    sym_d = !(run || load) ? '0 : wrap ? sym_c + N_MOD'(1) : sym_c;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '0;
      sym_q <= '0;
    end else begin
      slot_q <= slot_d;
      sym_q <= sym_d;
    end
  assign sym = sym_q;
  assign win_end = (slot_q == SW'(L - 1)) && (sym_q == '1);
endmodule

// File: rtl/oppm_decoder.sv
// oppm_decoder: locks on a symbol-0 preamble, decodes pulse positions into packets.
module oppm_decoder import oppm_pkg::*; #(
  parameter int N_MOD  = 2,
  parameter int L      = 8,
  parameter int N_PKT  = 8,
  parameter int PRE_CT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [N_PKT-1:0] data,
  output logic             valid,
  output logic             err,
  output logic             busy
);
  localparam int SYM_CT = sym_ct(N_PKT, N_MOD);
  localparam int PW = cnt_w(PRE_CT);
  localparam int DW = cnt_w(SYM_CT);
  if (N_PKT % N_MOD != 0 || L < 2 || PRE_CT < 1) begin : g_bad_cfg
    $error("oppm_decoder: N_PKT must be a multiple of N_MOD, L >= 2, PRE_CT >= 1");
  end
  logic [2:0] sync_q, sync_d;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d, pre_inc;
  logic [DW-1:0] dp_q, dp_d, dp_inc;
  logic seen_q, seen_d, valid_q, valid_d, err_q, err_d;
  logic [N_MOD-1:0] symr_q, symr_d, sym, sym_now;
  logic [N_PKT-1:0] sh_q, sh_d, data_q, data_d, shift;
  logic rise, load, win_end, seen_now;
  oppm_window_timer #(.N_MOD(N_MOD), .L(L)) u_timer (
    .clk(clk), .rst_n(rst_n), .run(state_q != HUNT), .load(load), .sym(sym), .win_end(win_end)
  );
  assign sync_d = {sync_q[1:0], pulse_in};
  assign rise = sync_q[1] & ~sync_q[2];
  assign pre_inc = pre_q + PW'(1);
  assign dp_inc = dp_q + DW'(1);
  // a rise landing on the window-end cycle belongs to the window being closed
  assign seen_now = seen_q | rise;
  assign sym_now = rise ? sym : symr_q;
  assign shift = (sh_q << N_MOD) | N_PKT'(sym_now);
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    dp_d = dp_q;
    seen_d = seen_q;
    symr_d = symr_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    load = 1'b0;
    case (state_q)
      HUNT, GAP: begin
        if (rise) begin
          load = 1'b1;
          pre_d = PW'(1);
          seen_d = 1'b1;
          state_d = (PRE_CT == 1) ? GAP : PREAM;
          err_d = state_q == GAP;
        end else if (state_q == GAP && win_end) begin
          state_d = DATA;
          dp_d = '0;
          seen_d = 1'b0;
        end
      end
      PREAM: begin
        if (rise) begin
          load = 1'b1;
          seen_d = 1'b1;
          pre_d = (sym == '0) ? pre_inc : PW'(1);
          state_d = (sym == '0 && pre_inc == PW'(PRE_CT)) ? GAP : PREAM;
        end else if (win_end) begin
          seen_d = 1'b0;
          state_d = seen_q ? PREAM : HUNT;
        end
      end
      default: begin
        if (rise && seen_q) begin
          err_d = 1'b1;
          state_d = HUNT;
        end else begin
          if (rise) begin
            symr_d = sym;
            seen_d = 1'b1;
          end
          if (win_end) begin
            if (!seen_now) begin
              err_d = 1'b1;
              state_d = HUNT;
            end else begin
              sh_d = shift;
              dp_d = dp_inc;
              seen_d = 1'b0;
              if (dp_inc == DW'(SYM_CT)) begin
                data_d = shift;
                valid_d = 1'b1;
                state_d = HUNT;
              end
            end
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= HUNT;
      pre_q <= '0;
      dp_q <= '0;
      seen_q <= 1'b0;
      symr_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      pre_q <= pre_d;
      dp_q <= dp_d;
      seen_q <= seen_d;
      symr_q <= symr_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign data = data_q;
  assign valid = valid_q;
  assign err = err_q;
  assign busy = state_q != HUNT;
endmodule
